// File: rtl/conv_calc_unit_pkg.sv
// Shared constants and operand-bus layout for the convolution dot-product engine.
// The layer controller packs its bus with the same opnd_lsb() helper.
package conv_calc_unit_pkg;

  localparam int WIDTH  = 16;
  localparam int FRAC   = 8;
  localparam int TAPS   = 25;
  localparam int ACC_W  = 37;
  localparam int PROD_W = 2 * WIDTH;
  localparam int BUS_W  = WIDTH * (2 * TAPS + 1);

  localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    OPND_A,
    OPND_B,
    OPND_BIAS
  } opnd_e;

  // LSB position of one operand word on the packed {VecA, VecB, Bias} bus.
  function automatic int opnd_lsb(input opnd_e kind, input int tap);
    case (kind)
      OPND_A:  return WIDTH * (TAPS + 1 + tap);
      OPND_B:  return WIDTH * (1 + tap);
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/conv_calc_unit_adder_tree_stage.sv
// One registered level of the reduction tree: N inputs summed pairwise into
// ceil(N/2) outputs; an odd last element passes through unchanged.
module adder_tree_stage #(
  parameter int N = 4,
  parameter int W = 37
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_valid,
  input  logic                i_relu,
  input  logic signed [W-1:0] i_data [N],
  output logic                o_valid,
  output logic                o_relu,
  output logic signed [W-1:0] o_data [(N+1)/2]
);

  localparam int M = (N + 1) / 2;

  logic signed [W-1:0] w_sum [M];

  for (genvar j = 0; j < M; j++) begin : g_pair
    if (2 * j + 1 < N) begin : g_add
      assign w_sum[j] = i_data[2*j] + i_data[2*j+1];
    end else begin : g_pass
      assign w_sum[j] = i_data[2*j];
    end
  end

  // NOTE: state is written with <= so every stage samples the previous stage's
  // pre-edge value; blocking writes here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_relu  <= 1'b0;
      // NOTE: datapath words are cleared as well, so no X can ever reach the output.
      for (int j = 0; j < M; j++) o_data[j] <= '0;
    end else if (!i_stall) begin
      o_valid <= i_valid;
      o_relu  <= i_relu;
      for (int j = 0; j < M; j++) o_data[j] <= w_sum[j];
    end
  end

endmodule

// File: rtl/conv_calc_unit.sv
// 8-stage pipelined Q8.8 dot product (25 taps) plus bias, with saturation and
// optional ReLU; one result per non-stalled clock, stall freezes every stage.
module conv_calc_unit
  import conv_calc_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] data_from_layer_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             relu_en_i,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic             busy_o
);

  localparam int L3       = (TAPS + 1) / 2;
  localparam int L4       = (L3 + 1) / 2;
  localparam int L5       = (L4 + 1) / 2;
  localparam int L6       = (L5 + 1) / 2;
  localparam int BIAS_DLY = 5;
  localparam logic signed [ACC_W-1:0] LIM_HI = {{(ACC_W-WIDTH){SAT_MAX[WIDTH-1]}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] LIM_LO = {{(ACC_W-WIDTH){SAT_MIN[WIDTH-1]}}, SAT_MIN};

  logic signed [WIDTH-1:0]  w_a [TAPS];
  logic signed [WIDTH-1:0]  w_b [TAPS];
  logic signed [WIDTH-1:0]  w_bias;
  logic signed [PROD_W-1:0] w_prod [TAPS];

  logic signed [WIDTH-1:0]  r_s1_a [TAPS];
  logic signed [WIDTH-1:0]  r_s1_b [TAPS];
  logic signed [WIDTH-1:0]  r_s1_bias;
  logic                     r_s1_valid, r_s1_relu;

  logic signed [ACC_W-1:0]  r_s2_prod [TAPS];
  logic                     r_s2_valid, r_s2_relu;
  logic signed [WIDTH-1:0]  r_bias_d [BIAS_DLY];

  logic signed [ACC_W-1:0]  w_s3_sum [L3];
  logic signed [ACC_W-1:0]  w_s4_sum [L4];
  logic signed [ACC_W-1:0]  w_s5_sum [L5];
  logic signed [ACC_W-1:0]  w_s6_sum [L6];
  logic                     w_s3_valid, w_s4_valid, w_s5_valid, w_s6_valid;
  logic                     w_s3_relu, w_s4_relu, w_s5_relu, w_s6_relu;

  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  r_s7_sum;
  logic                     r_s7_valid, r_s7_relu;

  logic signed [ACC_W-1:0]  w_shift;
  logic        [WIDTH-1:0]  w_sat;
  logic        [WIDTH-1:0]  r_result;
  logic                     r_result_valid;

  for (genvar i = 0; i < TAPS; i++) begin : g_unpack
    assign w_a[i]    = data_from_layer_i[opnd_lsb(OPND_A, i) +: WIDTH];
    assign w_b[i]    = data_from_layer_i[opnd_lsb(OPND_B, i) +: WIDTH];
    assign w_prod[i] = r_s1_a[i] * r_s1_b[i];
  end
  assign w_bias = data_from_layer_i[opnd_lsb(OPND_BIAS, 0) +: WIDTH];

  // S1 capture, S2 multiply; the bias rides a delay line until it joins at S7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_bias  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_relu  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_s1_a[i]    <= '0;
        r_s1_b[i]    <= '0;
        r_s2_prod[i] <= '0;
      end
      for (int i = 0; i < BIAS_DLY; i++) r_bias_d[i] <= '0;
    end else if (!stall_i) begin
      r_s1_valid <= valid_i;
      r_s1_relu  <= relu_en_i;
      r_s1_bias  <= w_bias;
      r_s2_valid <= r_s1_valid;
      r_s2_relu  <= r_s1_relu;
      for (int i = 0; i < TAPS; i++) begin
        r_s1_a[i]    <= w_a[i];
        r_s1_b[i]    <= w_b[i];
        r_s2_prod[i] <= {{(ACC_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
      end
      r_bias_d[0] <= r_s1_bias;
      for (int i = 1; i < BIAS_DLY; i++) r_bias_d[i] <= r_bias_d[i-1];
    end
  end

  adder_tree_stage #(.N(TAPS), .W(ACC_W)) u_s3 (
    .clk, .rst_n, .i_stall(stall_i),
    .i_valid(r_s2_valid), .i_relu(r_s2_relu), .i_data(r_s2_prod),
    .o_valid(w_s3_valid), .o_relu(w_s3_relu), .o_data(w_s3_sum)
  );

  adder_tree_stage #(.N(L3), .W(ACC_W)) u_s4 (
    .clk, .rst_n, .i_stall(stall_i),
    .i_valid(w_s3_valid), .i_relu(w_s3_relu), .i_data(w_s3_sum),
    .o_valid(w_s4_valid), .o_relu(w_s4_relu), .o_data(w_s4_sum)
  );

  adder_tree_stage #(.N(L4), .W(ACC_W)) u_s5 (
    .clk, .rst_n, .i_stall(stall_i),
    .i_valid(w_s4_valid), .i_relu(w_s4_relu), .i_data(w_s4_sum),
    .o_valid(w_s5_valid), .o_relu(w_s5_relu), .o_data(w_s5_sum)
  );

  adder_tree_stage #(.N(L5), .W(ACC_W)) u_s6 (
    .clk, .rst_n, .i_stall(stall_i),
    .i_valid(w_s5_valid), .i_relu(w_s5_relu), .i_data(w_s5_sum),
    .o_valid(w_s6_valid), .o_relu(w_s6_relu), .o_data(w_s6_sum)
  );

  // Final pair plus the Q16.16-aligned bias (L6 is 2 for a 25-tap kernel).
  assign w_bias_ext = {{(ACC_W-WIDTH){r_bias_d[BIAS_DLY-1][WIDTH-1]}}, r_bias_d[BIAS_DLY-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s7_sum   <= '0;
      r_s7_valid <= 1'b0;
      r_s7_relu  <= 1'b0;
    end else if (!stall_i) begin
      r_s7_sum   <= w_s6_sum[0] + w_s6_sum[1] + (w_bias_ext <<< FRAC);
      r_s7_valid <= w_s6_valid;
      r_s7_relu  <= w_s6_relu;
    end
  end

  assign w_shift = r_s7_sum >>> FRAC;

  // NOTE: w_sat gets a value on every path before any condition, so no latch is inferred.
  always_comb begin
    w_sat = w_shift[WIDTH-1:0];
    if (w_shift > LIM_HI)      w_sat = SAT_MAX;
    else if (w_shift < LIM_LO) w_sat = SAT_MIN;
    if (r_s7_relu && w_sat[WIDTH-1]) w_sat = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (!stall_i) begin
      r_result       <= w_sat;
      r_result_valid <= r_s7_valid;
    end
  end

  assign result_o       = r_result;
  assign result_valid_o = r_result_valid;
  assign busy_o         = r_s1_valid | r_s2_valid | w_s3_valid | w_s4_valid |
                          w_s5_valid | w_s6_valid | r_s7_valid | r_result_valid;

endmodule

// File: tb/tb_conv_calc_unit.sv
// Directed, table-driven bench for conv_calc_unit with hand-computed Q8.8 results.
module tb_conv_calc_unit;

  localparam int BW = 16 * 51;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] bus;
  logic          valid, stall, relu;
  logic [15:0]   result;
  logic          result_valid, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] a_fill, b_fill, a0, b0, bias;
    logic        relu;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [15];

  conv_calc_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_from_layer_i (bus),
    .valid_i           (valid),
    .stall_i           (stall),
    .relu_en_i         (relu),
    .result_o          (result),
    .result_valid_o    (result_valid),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tap 0 takes a0/b0, taps 1..24 take the fill values.
  function automatic logic [BW-1:0] pack(input logic [15:0] a_fill, input logic [15:0] b_fill,
                                         input logic [15:0] a0, input logic [15:0] b0,
                                         input logic [15:0] bias);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) begin
      v[16*(26+i) +: 16] = (i == 0) ? a0 : a_fill;
      v[16*(1+i)  +: 16] = (i == 0) ? b0 : b_fill;
    end
    v[15:0] = bias;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    bus   = pack(v.a_fill, v.b_fill, v.a0, v.b0, v.bias);
    relu  = v.relu;
    valid = 1'b1;
  endtask

  initial begin
    //           name           a_fill    b_fill    a0        b0        bias      relu  expected
    vecs[0]  = '{"unity",       16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1900};
    vecs[1]  = '{"neg",         16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0000, 1'b0, 16'hE700};
    vecs[2]  = '{"neg_relu",    16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{"sat_pos",     16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF};
    vecs[4]  = '{"sat_neg",     16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 16'h8000};
    vecs[5]  = '{"sat_neg_relu",16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{"mix_bias",    16'h0000, 16'h0000, 16'h0200, 16'h0180, 16'h0080, 1'b0, 16'h0380};
    vecs[7]  = '{"floor_neg",   16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF};
    vecs[8]  = '{"floor_pos",   16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{"hi_over1",    16'h0000, 16'h0000, 16'h0001, 16'h0100, 16'h7FFF, 1'b0, 16'h7FFF};
    vecs[10] = '{"hi_exact",    16'h0000, 16'h0000, 16'h0001, 16'h0100, 16'h7FFE, 1'b0, 16'h7FFF};
    vecs[11] = '{"lo_under1",   16'h0000, 16'h0000, 16'hFFFF, 16'h0100, 16'h8000, 1'b0, 16'h8000};
    vecs[12] = '{"lo_exact",    16'h0000, 16'h0000, 16'hFFFF, 16'h0100, 16'h8001, 1'b0, 16'h8000};
    vecs[13] = '{"pos_relu",    16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h1900};
    vecs[14] = '{"mixed_taps",  16'h0080, 16'h0200, 16'hFFC0, 16'h0400, 16'hFF80, 1'b0, 16'h1680};

    rst_n = 1'b0;
    valid = 1'b0;
    stall = 1'b0;
    relu  = 1'b0;
    bus   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 16'h0000);
    check("reset_valid", result_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse: valid for exactly one cycle, 8 clocks after presentation.
    @(negedge clk);
    drive_vec(vecs[0]);
    for (int p = 1; p <= 10; p++) begin
      @(posedge clk);
      #1;
      if (p == 1) valid = 1'b0;
      if (p == 1) check("pulse_busy", busy, 1'b1);
      if (p == 8) begin
        check("pulse_valid", result_valid, 1'b1);
        check("pulse_result", result, 16'h1900);
      end else begin
        check("pulse_novalid", result_valid, 1'b0);
      end
    end
    check("pulse_idle_busy", busy, 1'b0);

    // Table vectors streamed back-to-back; vector k shows after clock k+8.
    for (int p = 0; p < 25; p++) begin
      @(negedge clk);
      if (p < 15) drive_vec(vecs[p]);
      else valid = 1'b0;
      @(posedge clk);
      #1;
      if (p >= 7 && p - 7 < 15) begin
        check({"vld_", vecs[p-7].name}, result_valid, 1'b1);
        check(vecs[p-7].name, result, vecs[p-7].exp);
      end else begin
        check("stream_gap", result_valid, 1'b0);
      end
    end
    relu = 1'b0;

    // Ten bias-only sets with a 3-cycle stall while set 1 sits at the output.
    begin
      int issued = 0;
      int got    = 0;
      logic [15:0] prev_res;
      logic        prev_v;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        stall = (c >= 9 && c < 12);
        if (stall) begin
          bus   = pack(16'h0, 16'h0, 16'h0, 16'h0, 16'h5555);
          valid = 1'b1;
        end else if (issued < 10) begin
          bus   = pack(16'h0, 16'h0, 16'h0, 16'h0, 16'((issued + 1) << 8));
          valid = 1'b1;
        end else begin
          valid = 1'b0;
        end
        prev_res = result;
        prev_v   = result_valid;
        @(posedge clk);
        #1;
        if (stall) begin
          check("stall_hold_result", result, prev_res);
          check("stall_hold_valid", result_valid, prev_v);
          check("stall_held_value", result, 16'h0200);
          check("stall_held_vld", result_valid, 1'b1);
        end else begin
          if (valid) issued++;
          if (result_valid) begin
            if (got < 10) check("stream_order", result, 16'((got + 1) << 8));
            got++;
          end
        end
      end
      stall = 1'b0;
      valid = 1'b0;
      check("stream_count", got, 10);
      check("stream_idle_busy", busy, 1'b0);
    end

    // Reset while four sets are in flight.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_vec(vecs[0]);
      @(posedge clk);
    end
    #2;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", result_valid, 1'b0);
    check("midrst_result", result, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int late = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        #1;
        if (result_valid || busy) late++;
      end
      check("post_rst_quiet", late, 0);
    end

    // Fresh set after reset, latency bounded by a cycle budget.
    begin
      int lat = 0;
      @(negedge clk);
      drive_vec(vecs[14]);
      for (int n = 1; n <= 12; n++) begin
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (result_valid) begin
          lat = n;
          break;
        end
      end
      check("fresh_latency", lat, 8);
      check("fresh_result", result, 16'h1680);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
